regfile_scoreboard: RTL



---
 rtl/regfile_scoreboard.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Parametrised register file with two combinational read ports, one write
//   port, write-to-read bypass and a per-register pending-write scoreboard
//   so decode can detect RAW hazards and stall.
//
// Parameters
//   DATA_W  register width
//   ADDR_W  index width (depth = 2**ADDR_W)
//   PEND_W  pending counter width (max in-flight writes = 2**PEND_W-1)
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   ReadRegister1/2 -> ReadData1/2 combinational reads with bypass
//   Busy1/2                       read register has an outstanding write
//   RegWrite, WriteRegister, WriteData  writeback port
//   IssueValid, IssueRegister     decode issues a write to IssueRegister
//   IssueReady                    issue accepted (counter below maximum)
//   Flush                         clear all pending counters
//
// Compile-time option
//   REGFILE_ZERO_REG_EN  register 0 hardwired to zero, never busy,
//                        issues to it accepted but not counted.

module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueRegister,
    output logic              IssueReady,
    input  logic              Flush
);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] mem_q  [DEPTH];
    logic [DATA_W-1:0] mem_d  [DEPTH];
    logic [PEND_W-1:0] pend_q [DEPTH];
    logic [PEND_W-1:0] pend_d [DEPTH];

    logic wr_en;
    logic issue_inc;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] idx);
        return ZERO_REG && (idx == '0);
    endfunction

    // Bypass is suppressed in reset; reads in reset show stored contents.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
        if (is_zero_reg(ra))
            return '0;
        else if (rst_n && RegWrite && (WriteRegister == ra))
            return WriteData;
        else
            return mem_q[ra];
    endfunction

    // A register whose last outstanding write is being written back this
    // cycle is not busy: the bypass already supplies the final value.
    function automatic logic busy_port(input logic [ADDR_W-1:0] ra);
        logic last_wb;
        last_wb = (pend_q[ra] == PEND_ONE) && RegWrite && (WriteRegister == ra);
        return rst_n && !is_zero_reg(ra) && (pend_q[ra] != '0) && !last_wb;
    endfunction

    always_comb begin
        ReadData1 = read_port(ReadRegister1);
        ReadData2 = read_port(ReadRegister2);
        Busy1     = busy_port(ReadRegister1);
        Busy2     = busy_port(ReadRegister2);
    end

    always_comb begin
        IssueReady = 1'b0;
        if (rst_n) begin
            if (is_zero_reg(IssueRegister))
                IssueReady = 1'b1;
            else
                IssueReady = (pend_q[IssueRegister] != PEND_MAX);
        end
    end

    assign wr_en     = rst_n && RegWrite && !is_zero_reg(WriteRegister);
    assign issue_inc = rst_n && IssueValid && IssueReady && !Flush &&
                       !is_zero_reg(IssueRegister);

    always_comb begin
        mem_d = mem_q;
        if (wr_en)
            mem_d[WriteRegister] = WriteData;
    end

    always_comb begin
        logic inc;
        logic dec;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            inc = issue_inc && (IssueRegister == ADDR_W'(i));
            dec = RegWrite && (WriteRegister == ADDR_W'(i)) && (pend_q[i] != '0);
            pend_d[i] = pend_q[i];
            if (Flush)
                pend_d[i] = '0;
            else if (inc && !dec)
                pend_d[i] = pend_q[i] + PEND_ONE;
            else if (dec && !inc)
                pend_d[i] = pend_q[i] - PEND_ONE;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!rst_n) begin
                mem_q[i]  <= '0;
                pend_q[i] <= '0;
            end else begin
                mem_q[i]  <= mem_d[i];
                pend_q[i] <= pend_d[i];
            end
        end
    end

endmodule
